// File: rtl/apb_master_arbiter6_pkg.sv
// Shared types and constants for the APB master arbiter: FSM state encoding,
// slave-select field geometry and the one-hot slave decode helper.
package apb_arb_pkg6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam int SEL_W = 4;
  localparam int NSLV  = 16;

  function automatic logic [NSLV-1:0] sel_decode(input logic [SEL_W-1:0] field);
    logic [NSLV-1:0] onehot;
    onehot        = '0;
    onehot[field] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/apb_master_arbiter6_picker.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, scanning upward with wrap-around.
module apb_rr_picker6 #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    int              pos;
    logic [IDXW-1:0] slot;
    logic            found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      slot = IDXW'(pos);
      if (!found && req_i[slot]) begin
        found         = 1'b1;
        idx_o         = slot;
        grant_o[slot] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/apb_master_arbiter6.sv
// APB master sequencer shared by NREQ6 requesters: round-robin arbitration,
// SETUP/ACCESS phase generation, one-hot slave select and wait-state timeout.
module apb_master_arbiter6
  import apb_arb_pkg6::*;
#(
  parameter int NREQ6         = 4,
  parameter int PADDR_WIDTH6  = 32,
  parameter int PWDATA_WIDTH6 = 32,
  parameter int PRDATA_WIDTH6 = 32,
  parameter int SEL_LSB6      = 12,
  parameter int TIMEOUT6      = 256
) (
  input  logic                            pclock6,
  input  logic                            preset6,
  input  logic [NREQ6-1:0]                req_valid6,
  input  logic [NREQ6-1:0]                req_write6,
  input  logic [NREQ6*PADDR_WIDTH6-1:0]   req_addr6,
  input  logic [NREQ6*PWDATA_WIDTH6-1:0]  req_wdata6,
  output logic [NREQ6-1:0]                req_ready6,
  output logic [NREQ6-1:0]                rsp_valid6,
  output logic [PRDATA_WIDTH6-1:0]        rsp_rdata6,
  output logic                            rsp_slverr6,
  output logic [PADDR_WIDTH6-1:0]         paddr6,
  output logic                            prwd6,
  output logic [PWDATA_WIDTH6-1:0]        pwdata6,
  output logic [NSLV-1:0]                 psel6,
  output logic                            penable6,
  input  logic                            pready6,
  input  logic [PRDATA_WIDTH6-1:0]        prdata6,
  input  logic                            pslverr6
);

  localparam int IDXW = $clog2(NREQ6);
  localparam int TW   = (TIMEOUT6 > 0) ? $clog2(TIMEOUT6 + 1) : 1;
  localparam logic [TW-1:0]   TLAST = TW'((TIMEOUT6 > 0) ? TIMEOUT6 - 1 : 0);
  localparam logic [IDXW-1:0] ILAST = IDXW'(NREQ6 - 1);

  state_e                     state_q,      state_d;
  logic [IDXW-1:0]            rr_ptr_q,     rr_ptr_d;
  logic [IDXW-1:0]            gidx_q,       gidx_d;
  logic [TW-1:0]              timer_q,      timer_d;
  logic [PADDR_WIDTH6-1:0]    paddr_q,      paddr_d;
  logic                       prwd_q,       prwd_d;
  logic [PWDATA_WIDTH6-1:0]   pwdata_q,     pwdata_d;
  logic [NSLV-1:0]            psel_q,       psel_d;
  logic                       penable_q,    penable_d;
  logic [NREQ6-1:0]           req_ready_q,  req_ready_d;
  logic [NREQ6-1:0]           rsp_valid_q,  rsp_valid_d;
  logic [PRDATA_WIDTH6-1:0]   rsp_rdata_q,  rsp_rdata_d;
  logic                       rsp_slverr_q, rsp_slverr_d;

  logic [IDXW-1:0]            next_ptr;
  logic [IDXW-1:0]            arb_ptr;
  logic [NREQ6-1:0]           pick_grant;
  logic [IDXW-1:0]            pick_idx;
  logic                       pick_any;
  logic                       timed_out;
  logic                       done;
  logic                       start;
  logic [PADDR_WIDTH6-1:0]    pick_addr;

  // On completion the pointer moves past the finishing requester, and a
  // back-to-back grant must already see that updated pointer.
  assign next_ptr = (gidx_q == ILAST) ? '0 : gidx_q + 1'b1;
  assign arb_ptr  = (state_q == ST_ACCESS) ? next_ptr : rr_ptr_q;

  apb_rr_picker6 #(
    .NREQ (NREQ6),
    .IDXW (IDXW)
  ) u_picker (
    .req_i   (req_valid6),
    .ptr_i   (arb_ptr),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign pick_addr = req_addr6[int'(pick_idx)*PADDR_WIDTH6 +: PADDR_WIDTH6];
  assign timed_out = (TIMEOUT6 != 0) && !pready6 && (timer_q == TLAST);
  assign done      = pready6 || timed_out;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gidx_d       = gidx_q;
    timer_d      = timer_q;
    paddr_d      = paddr_q;
    prwd_d       = prwd_q;
    pwdata_d     = pwdata_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_slverr_d = 1'b0;
    start        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start = pick_any;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        timer_d   = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (done) begin
          rsp_valid_d[gidx_q] = 1'b1;
          rsp_rdata_d         = (prwd_q || timed_out) ? '0 : prdata6;
          rsp_slverr_d        = (pready6 && pslverr6) || timed_out;
          penable_d           = 1'b0;
          psel_d              = '0;
          rr_ptr_d            = next_ptr;
          state_d             = ST_IDLE;
          start               = pick_any;
        end else if (!(&timer_q)) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new grant overrides the IDLE fallback, so completion chains straight
    // into SETUP without a dead cycle.
    if (start) begin
      gidx_d      = pick_idx;
      paddr_d     = pick_addr;
      prwd_d      = req_write6[pick_idx];
      pwdata_d    = req_wdata6[int'(pick_idx)*PWDATA_WIDTH6 +: PWDATA_WIDTH6];
      psel_d      = sel_decode(pick_addr[SEL_LSB6 +: SEL_W]);
      penable_d   = 1'b0;
      req_ready_d = pick_grant;
      state_d     = ST_SETUP;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before the edge, independent of block ordering.
  always_ff @(posedge pclock6 or negedge preset6) begin
    if (!preset6) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gidx_q       <= '0;
      timer_q      <= '0;
      paddr_q      <= '0;
      prwd_q       <= 1'b0;
      pwdata_q     <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gidx_q       <= gidx_d;
      timer_q      <= timer_d;
      paddr_q      <= paddr_d;
      prwd_q       <= prwd_d;
      pwdata_q     <= pwdata_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
    end
  end

  assign req_ready6  = req_ready_q;
  assign rsp_valid6  = rsp_valid_q;
  assign rsp_rdata6  = rsp_rdata_q;
  assign rsp_slverr6 = rsp_slverr_q;
  assign paddr6      = paddr_q;
  assign prwd6       = prwd_q;
  assign pwdata6     = pwdata_q;
  assign psel6       = psel_q;
  assign penable6    = penable_q;

endmodule

// File: tb/tb_apb_master_arbiter6.sv
// Self-checking bench for apb_master_arbiter6: directed scenarios plus random
// traffic against a transaction-level round-robin / APB response model.
module tb_apb_master_arbiter6;

  localparam int N       = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TMO     = 8;
  localparam int SEL_LSB = 12;

  logic              pclock6 = 1'b0;
  logic              preset6;
  logic [N-1:0]      req_valid6;
  logic [N-1:0]      req_write6;
  logic [N*AW-1:0]   req_addr6;
  logic [N*DW-1:0]   req_wdata6;
  logic [N-1:0]      req_ready6;
  logic [N-1:0]      rsp_valid6;
  logic [DW-1:0]     rsp_rdata6;
  logic              rsp_slverr6;
  logic [AW-1:0]     paddr6;
  logic              prwd6;
  logic [DW-1:0]     pwdata6;
  logic [15:0]       psel6;
  logic              penable6;
  logic              pready6;
  logic [DW-1:0]     prdata6;
  logic              pslverr6;

  int checks = 0;
  int errors = 0;
  int ptr;
  logic [AW-1:0] m_addr  [N];
  logic [DW-1:0] m_wdata [N];
  logic          m_wr    [N];

  apb_master_arbiter6 #(
    .NREQ6         (N),
    .PADDR_WIDTH6  (AW),
    .PWDATA_WIDTH6 (DW),
    .PRDATA_WIDTH6 (DW),
    .SEL_LSB6      (SEL_LSB),
    .TIMEOUT6      (TMO)
  ) dut (
    .pclock6     (pclock6),
    .preset6     (preset6),
    .req_valid6  (req_valid6),
    .req_write6  (req_write6),
    .req_addr6   (req_addr6),
    .req_wdata6  (req_wdata6),
    .req_ready6  (req_ready6),
    .rsp_valid6  (rsp_valid6),
    .rsp_rdata6  (rsp_rdata6),
    .rsp_slverr6 (rsp_slverr6),
    .paddr6      (paddr6),
    .prwd6       (prwd6),
    .pwdata6     (pwdata6),
    .psel6       (psel6),
    .penable6    (penable6),
    .pready6     (pready6),
    .prdata6     (prdata6),
    .pslverr6    (pslverr6)
  );

  always #5 pclock6 = ~pclock6;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclock6);
    #1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_addr6[i*AW +: AW]  = m_addr[i];
      req_wdata6[i*DW +: DW] = m_wdata[i];
      req_write6[i]          = m_wr[i];
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    m_addr[i]     = a;
    m_wr[i]       = w;
    m_wdata[i]    = d;
    req_valid6[i] = 1'b1;
    drive_req();
  endtask

  function automatic int model_pick(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++)
      if (mask[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_psel"},    psel6,       0);
    check({tag, "_penable"}, penable6,    0);
    check({tag, "_ready"},   req_ready6,  0);
    check({tag, "_rspv"},    rsp_valid6,  0);
    check({tag, "_rdata"},   rsp_rdata6,  0);
    check({tag, "_slverr"},  rsp_slverr6, 0);
    check({tag, "_paddr"},   paddr6,      0);
    check({tag, "_prwd"},    prwd6,       0);
    check({tag, "_pwdata"},  pwdata6,     0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_psel"},    psel6,    0);
    check({tag, "_idle_penable"}, penable6, 0);
  endtask

  // Expects the DUT to be in the SETUP cycle for requester g right now, plays
  // the slave for `waits` wait states (>= TMO means never ready) and checks the
  // response. Returns in the completion cycle.
  task automatic do_xfer(input int g, input int waits, input logic [DW-1:0] rd, input logic err);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    logic [15:0]   esel;
    bit            tmo;
    ea   = m_addr[g];
    ed   = m_wdata[g];
    ew   = m_wr[g];
    esel = 16'd1 << ea[SEL_LSB +: 4];
    tmo  = (waits >= TMO);
    check("setup_psel",    psel6,      esel);
    check("setup_penable", penable6,   0);
    check("setup_paddr",   paddr6,     ea);
    check("setup_prwd",    prwd6,      ew);
    check("setup_pwdata",  pwdata6,    ed);
    check("setup_ready",   req_ready6, 64'd1 << g);
    // Accepted: requester drops and is free to scramble its fields.
    req_valid6[g] = 1'b0;
    m_addr[g]     = $urandom;
    m_wdata[g]    = $urandom;
    m_wr[g]       = 1'($urandom);
    drive_req();
    pready6 = 1'b0;
    step();
    for (int k = 0; k < TMO; k++) begin
      check("access_penable", penable6,   1);
      check("access_psel",    psel6,      esel);
      check("access_paddr",   paddr6,     ea);
      check("access_ready",   req_ready6, 0);
      check("access_rspv",    rsp_valid6, 0);
      if (!tmo && k == waits) begin
        pready6  = 1'b1;
        prdata6  = rd;
        pslverr6 = err;
      end else begin
        pready6  = 1'b0;
        prdata6  = $urandom;
        pslverr6 = 1'($urandom);
      end
      step();
      pready6  = 1'b0;
      pslverr6 = 1'b0;
      if ((!tmo && k == waits) || (tmo && k == TMO - 1)) break;
    end
    check("rsp_valid",    rsp_valid6,  64'd1 << g);
    check("rsp_rdata",    rsp_rdata6,  (ew || tmo) ? 64'd0 : 64'(rd));
    check("rsp_slverr",   rsp_slverr6, tmo ? 64'd1 : 64'(err));
    check("done_penable", penable6,    0);
    ptr = (g + 1) % N;
  endtask

  task automatic raise_random(input bit force_one);
    for (int i = 0; i < N; i++)
      if (!req_valid6[i] && $urandom_range(0, 2) == 0)
        set_req(i, $urandom, 1'($urandom), $urandom);
    if (force_one && req_valid6 == '0)
      set_req($urandom_range(0, N - 1), $urandom, 1'($urandom), $urandom);
  endtask

  initial begin
    int nxt;
    preset6    = 1'b0;
    req_valid6 = '0;
    req_write6 = '0;
    req_addr6  = '0;
    req_wdata6 = '0;
    pready6    = 1'b0;
    prdata6    = '0;
    pslverr6   = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_addr[i]  = '0;
      m_wdata[i] = '0;
      m_wr[i]    = 1'b0;
    end
    ptr = 0;

    #1;
    check_reset("por");
    step();
    step();
    preset6 = 1'b1;
    step();
    check_idle("post_rst");

    // Single read from requester 1, two wait states.
    set_req(1, 32'h0000_3010, 1'b0, 32'h1234_5678);
    step();
    check("single_psel", psel6, 16'h0008);
    do_xfer(1, 2, 32'hCAFE_F00D, 1'b0);
    check_idle("single");

    // Contention from reset: grants 0,1,2,3 with no IDLE gap.
    preset6 = 1'b0;
    #1;
    check_reset("rst2");
    step();
    preset6 = 1'b1;
    ptr     = 0;
    for (int i = 0; i < N; i++) set_req(i, $urandom, 1'($urandom), $urandom);
    step();
    for (int i = 0; i < N; i++) do_xfer(i, $urandom_range(0, 3), $urandom, 1'($urandom));
    check_idle("contention");

    // Fairness: requesters 0 and 2 keep coming back; must alternate.
    set_req(0, $urandom, 1'b0, $urandom);
    set_req(2, $urandom, 1'b1, $urandom);
    step();
    for (int k = 0; k < 6; k++) begin
      int g;
      g = (k % 2 == 0) ? 0 : 2;
      do_xfer(g, $urandom_range(0, 2), $urandom, 1'b0);
      if (k < 4) set_req(g, $urandom, 1'($urandom), $urandom);
    end
    check_idle("fairness");

    // Slave error on a write.
    set_req(3, 32'h0000_5004, 1'b1, 32'hA5A5_5A5A);
    step();
    do_xfer(3, 1, 32'hFFFF_FFFF, 1'b1);
    check_idle("slverr");

    // Timeout: slave never ready.
    set_req(1, 32'h0000_7000, 1'b0, 32'h0);
    step();
    do_xfer(1, 99, 32'hDEAD_BEEF, 1'b0);
    check_idle("timeout");

    // Random traffic against the model.
    nxt = -1;
    for (int t = 0; t < 40; t++) begin
      if (nxt < 0) begin
        check_idle("rand");
        raise_random(1'b1);
        step();
        nxt = model_pick(req_valid6, ptr);
      end else begin
        raise_random(1'b0);
      end
      do_xfer(nxt, $urandom_range(0, 10), $urandom, 1'($urandom));
      nxt = model_pick(req_valid6, ptr);
    end
    for (int t = 0; t < N && nxt >= 0; t++) begin
      do_xfer(nxt, $urandom_range(0, 3), $urandom, 1'($urandom));
      nxt = model_pick(req_valid6, ptr);
    end
    check_idle("drain");

    // Reset in the middle of ACCESS: pointer left at 2 before reset.
    set_req(1, $urandom, 1'b0, $urandom);
    step();
    do_xfer(1, 0, $urandom, 1'b0);
    set_req(2, 32'h0000_F000, 1'b1, 32'h0BAD_0BAD);
    step();
    check("mid_setup_psel", psel6, 16'h8000);
    req_valid6[2] = 1'b0;
    step();
    check("mid_access_penable", penable6, 1);
    preset6 = 1'b0;
    #1;
    check_reset("rst_mid");
    pready6 = 1'b1;
    step();
    check("rst_mid_no_rsp", rsp_valid6, 0);
    pready6 = 1'b0;
    preset6 = 1'b1;
    ptr     = 0;
    set_req(3, $urandom, 1'($urandom), $urandom);
    set_req(0, $urandom, 1'($urandom), $urandom);
    step();
    do_xfer(0, 0, $urandom, 1'b0);
    do_xfer(3, 1, $urandom, 1'b0);
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
